// File: rtl/axil_cpu_master.sv
// CPU single-outstanding load/store port bridged onto an AXI4-Lite master.
// Optional AXIL_MASTER_POSTED_WRITE_EN: stores complete before the B response.
module axil_cpu_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic                  mem_done,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_err,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WADDR = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] RADDR = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done;
    logic                  w_done;

    // A channel counts as done once its valid has dropped or is handshaking now
    assign aw_done = !m_axil_awvalid || m_axil_awready;
    assign w_done  = !m_axil_wvalid || m_axil_wready;

    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_rready = (state == RDATA);
    assign mem_done      = (state == DONE);

`ifdef AXIL_MASTER_POSTED_WRITE_EN
    logic b_pending;

    assign m_axil_bready = (state == WRESP) || b_pending;
    assign mem_ready     = (state == IDLE) && !b_pending;
`else
    assign m_axil_bready = (state == WRESP);
    assign mem_ready     = (state == IDLE);
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            mem_rdata      <= '0;
            mem_err        <= 1'b0;
`ifdef AXIL_MASTER_POSTED_WRITE_EN
            b_pending      <= 1'b0;
`endif
        end else begin
`ifdef AXIL_MASTER_POSTED_WRITE_EN
            if (b_pending && m_axil_bvalid) begin
                b_pending <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (mem_valid && mem_ready) begin
                        addr_q  <= mem_addr & WORD_MASK;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        if (mem_we) begin
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= WADDR;
                        end else begin
                            m_axil_arvalid <= 1'b1;
                            state          <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    if (m_axil_awready) begin
                        m_axil_awvalid <= 1'b0;
                    end
                    if (m_axil_wready) begin
                        m_axil_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
`ifdef AXIL_MASTER_POSTED_WRITE_EN
                        mem_err   <= 1'b0;
                        b_pending <= 1'b1;
                        state     <= DONE;
`else
                        state <= WRESP;
`endif
                    end
                end
                WRESP: begin
                    if (m_axil_bvalid) begin
                        mem_err <= |m_axil_bresp;
                        state   <= DONE;
                    end
                end
                RADDR: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        state          <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axil_rvalid) begin
                        mem_rdata <= m_axil_rdata;
                        mem_err   <= |m_axil_rresp;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cpu_master.sv
// Directed testbench for axil_cpu_master with a small AXI-Lite slave model.
// Latency expectations follow AXIL_MASTER_POSTED_WRITE_EN when it is defined.
module tb_axil_cpu_master;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int failures = 0;

`ifdef AXIL_MASTER_POSTED_WRITE_EN
    localparam int WR_LAT   = 2;
    localparam int BD_DONE  = 2;
    localparam int BD_READY = 8;
    localparam logic BD_ERR = 1'b0;
`else
    localparam int WR_LAT   = 4;
    localparam int BD_DONE  = 8;
    localparam int BD_READY = 9;
    localparam logic BD_ERR = 1'b1;
`endif

    always #5 clk = ~clk;

    axil_cpu_master dut (
        .aclk          (clk),
        .areset        (areset),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err),
        .m_axil_awaddr (awaddr),
        .m_axil_awprot (awprot),
        .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata  (wdata),
        .m_axil_wstrb  (wstrb),
        .m_axil_wvalid (wvalid),
        .m_axil_wready (wready),
        .m_axil_bresp  (bresp),
        .m_axil_bvalid (bvalid),
        .m_axil_bready (bready),
        .m_axil_araddr (araddr),
        .m_axil_arprot (arprot),
        .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata  (rdata),
        .m_axil_rresp  (rresp),
        .m_axil_rvalid (rvalid),
        .m_axil_rready (rready)
    );

    // Slave model: each ready rises after a configurable number of valid cycles
    int aw_delay = 0;
    int w_delay = 0;
    int ar_delay = 0;
    int b_delay = 0;
    int r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] rresp_cfg = 2'b00;

    logic [31:0] smem [0:255];
    int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic aw_got, w_got, b_busy, r_busy;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0] w_s;

    assign awready = (aw_wait >= aw_delay);
    assign wready  = (w_wait >= w_delay);
    assign arready = (ar_wait >= ar_delay);

    always @(posedge clk) begin
        if (areset) begin
            aw_wait <= 0;
            w_wait  <= 0;
            ar_wait <= 0;
            b_cnt   <= 0;
            r_cnt   <= 0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            b_busy  <= 1'b0;
            r_busy  <= 1'b0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            bresp   <= 2'b00;
            rresp   <= 2'b00;
            rdata   <= '0;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (awvalid && awready) begin
                aw_wait <= 0;
                aw_got  <= 1'b1;
                aw_a    <= awaddr;
            end else if (awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (wvalid && wready) begin
                w_wait <= 0;
                w_got  <= 1'b1;
                w_d    <= wdata;
                w_s    <= wstrb;
            end else if (wvalid) begin
                w_wait <= w_wait + 1;
            end
            if (aw_got && w_got) begin
                for (int i = 0; i < 4; i++)
                    if (w_s[i]) smem[aw_a[9:2]][8*i +: 8] <= w_d[8*i +: 8];
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bresp  <= bresp_cfg;
                if (b_delay == 0) bvalid <= 1'b1;
                else begin
                    b_busy <= 1'b1;
                    b_cnt  <= b_delay;
                end
            end
            if (b_busy) begin
                b_cnt <= b_cnt - 1;
                if (b_cnt == 1) begin
                    bvalid <= 1'b1;
                    b_busy <= 1'b0;
                end
            end
            if (arvalid && arready) begin
                ar_wait <= 0;
                ar_a    <= araddr;
                rresp   <= rresp_cfg;
                if (r_delay == 0) begin
                    rvalid <= 1'b1;
                    rdata  <= smem[araddr[9:2]];
                end else begin
                    r_busy <= 1'b1;
                    r_cnt  <= r_delay;
                end
            end else if (arvalid) begin
                ar_wait <= ar_wait + 1;
            end
            if (r_busy) begin
                r_cnt <= r_cnt - 1;
                if (r_cnt == 1) begin
                    rvalid <= 1'b1;
                    rdata  <= smem[ar_a[9:2]];
                    r_busy <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the sample point of cycle 1 of the request
    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int g = 0;
        while (mem_ready !== 1'b1 && g < 200) begin
            tick();
            g++;
        end
        mem_valid = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        tick();
        mem_valid = 1'b0;
    endtask

    // n = request-relative cycle of mem_done, or -1 on timeout
    task automatic wait_done(output int n);
        n = 1;
        while (mem_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (mem_done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, mem_done, mem_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b expected 0000000",
                     {awvalid, wvalid, arvalid, bready, rready, mem_done, mem_err});
        end
        checks++;
        if (mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got %h expected 00000000", mem_rdata);
        end
        checks++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b expected 1", mem_ready);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_store_basic();
        int n;
        issue(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b11000) begin
            failures++;
            $display("FAIL store_c1_valids got %b expected 11000",
                     {awvalid, wvalid, arvalid, bready, rready});
        end
        checks++;
        if (awaddr !== 32'h0000_0104 || awprot !== 3'b000) begin
            failures++;
            $display("FAIL store_awaddr got %h/%b expected 00000104/000", awaddr, awprot);
        end
        checks++;
        if (wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
            failures++;
            $display("FAIL store_wdata got %h/%h expected deadbeef/f", wdata, wstrb);
        end
        wait_done(n);
        checks++;
        if (n !== WR_LAT) begin
            failures++;
            $display("FAIL store_latency got %0d expected %0d", n, WR_LAT);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            failures++;
            $display("FAIL store_err got %b expected 0", mem_err);
        end
        tick();
        checks++;
        if ({mem_done, mem_ready} !== {1'b0, WR_LAT == 4}) begin
            failures++;
            $display("FAIL store_after_done got %b expected %b",
                     {mem_done, mem_ready}, {1'b0, WR_LAT == 4});
        end
        issue(1'b0, 32'h0000_0107, 32'h0, 4'h0);
        checks++;
        if (araddr !== 32'h0000_0104 || arprot !== 3'b000
            || {arvalid, awvalid, wvalid} !== 3'b100) begin
            failures++;
            $display("FAIL load_c1 got %h/%b/%b expected 00000104/000/100",
                     araddr, arprot, {arvalid, awvalid, wvalid});
        end
        wait_done(n);
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL load_latency got %0d expected 3", n);
        end
        checks++;
        if (mem_rdata !== 32'hDEAD_BEEF || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL load_data got %h/%b expected deadbeef/0", mem_rdata, mem_err);
        end
        tick();
    endtask

    task automatic test_strobe();
        int n;
        issue(1'b1, 32'h0000_0108, 32'h1122_3344, 4'hF);
        wait_done(n);
        issue(1'b1, 32'h0000_0108, 32'h0000_AA00, 4'b0010);
        wait_done(n);
        checks++;
        if (n !== WR_LAT) begin
            failures++;
            $display("FAIL strobe_latency got %0d expected %0d", n, WR_LAT);
        end
        issue(1'b0, 32'h0000_0108, 32'h0, 4'h0);
        wait_done(n);
        checks++;
        if (mem_rdata !== 32'h1122_AA44) begin
            failures++;
            $display("FAIL strobe_readback got %h expected 1122aa44", mem_rdata);
        end
        tick();
    endtask

    task automatic test_wready_stall();
        int aw_n = 0;
        int w_n = 0;
        int bad = 0;
        int dn = 0;
        w_delay = 5;
        issue(1'b1, 32'h0000_010C, 32'h5A5A_0001, 4'hF);
        for (int i = 0; i < 14; i++) begin
            if (awvalid === 1'b1) aw_n++;
            if (wvalid === 1'b1) begin
                w_n++;
                if (wdata !== 32'h5A5A_0001 || wstrb !== 4'hF) bad++;
            end
            if (mem_done === 1'b1) dn++;
            tick();
        end
        w_delay = 0;
        checks++;
        if (aw_n !== 1) begin
            failures++;
            $display("FAIL stall_aw_cycles got %0d expected 1", aw_n);
        end
        checks++;
        if (w_n !== 6) begin
            failures++;
            $display("FAIL stall_w_cycles got %0d expected 6", w_n);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_w_payload got %0d unstable expected 0", bad);
        end
        checks++;
        if (dn !== 1) begin
            failures++;
            $display("FAIL stall_done_pulses got %0d expected 1", dn);
        end
    endtask

    task automatic test_read_error();
        int n;
        issue(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF);
        wait_done(n);
        ar_delay  = 3;
        r_delay   = 2;
        rresp_cfg = 2'b10;
        issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        wait_done(n);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL rderr_latency got %0d expected 8", n);
        end
        checks++;
        if (mem_err !== 1'b1) begin
            failures++;
            $display("FAIL rderr_err got %b expected 1", mem_err);
        end
        checks++;
        if (mem_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL rderr_data got %h expected cafef00d", mem_rdata);
        end
        ar_delay  = 0;
        r_delay   = 0;
        rresp_cfg = 2'b00;
        tick();
        checks++;
        if (mem_done !== 1'b0 || mem_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL rderr_hold got %b/%h expected 0/cafef00d", mem_done, mem_rdata);
        end
    endtask

    task automatic test_busy_reset();
        int n;
        ar_delay = 10;
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        tick();
        checks++;
        if (mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready got %b expected 0", mem_ready);
        end
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0300;
        mem_wdata = 32'h0BAD_F00D;
        mem_wstrb = 4'hF;
        tick();
        mem_valid = 1'b0;
        checks++;
        if ({awvalid, wvalid, arvalid} !== 3'b001 || araddr !== 32'h0000_0104) begin
            failures++;
            $display("FAIL busy_ignored got %b/%h expected 001/00000104",
                     {awvalid, wvalid, arvalid}, araddr);
        end
        areset = 1'b1;
        tick();
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, mem_done, mem_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL midreset_ctrl got %b expected 0000001",
                     {awvalid, wvalid, arvalid, bready, rready, mem_done, mem_ready});
        end
        checks++;
        if (mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL midreset_rdata got %h expected 00000000", mem_rdata);
        end
        areset   = 1'b0;
        ar_delay = 0;
        tick();
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        wait_done(n);
        checks++;
        if (n !== 3 || mem_rdata !== 32'hDEAD_BEEF || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL postreset_load got %0d/%h/%b expected 3/deadbeef/0",
                     n, mem_rdata, mem_err);
        end
        tick();
    endtask

    task automatic test_b_delay();
        int n;
        int r;
        b_delay   = 4;
        bresp_cfg = 2'b10;
        issue(1'b1, 32'h0000_0110, 32'h0BAD_0BAD, 4'hF);
        wait_done(n);
        checks++;
        if (n !== BD_DONE) begin
            failures++;
            $display("FAIL bdelay_done got %0d expected %0d", n, BD_DONE);
        end
        checks++;
        if (mem_err !== BD_ERR) begin
            failures++;
            $display("FAIL bdelay_err got %b expected %b", mem_err, BD_ERR);
        end
        r = n;
        while (mem_ready !== 1'b1 && r < 60) begin
            tick();
            r++;
        end
        checks++;
        if (r !== BD_READY) begin
            failures++;
            $display("FAIL bdelay_ready got %0d expected %0d", r, BD_READY);
        end
        b_delay   = 0;
        bresp_cfg = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [3] = '{32'h0000_0400, 32'h0000_0404, 32'h0000_0408};
        logic [31:0] td [3] = '{32'h0102_0304, 32'hA5A5_A5A5, 32'hFFFF_0000};
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, ta[i], td[i], 4'hF);
            wait_done(n);
        end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, ta[i], 32'h0, 4'h0);
            wait_done(n);
            checks++;
            if (n !== 3 || mem_rdata !== td[i]) begin
                failures++;
                $display("FAIL b2b_load%0d got %0d/%h expected 3/%h", i, n, mem_rdata, td[i]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_basic();
        test_strobe();
        test_wready_stall();
        test_read_error();
        test_busy_reset();
        test_b_delay();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_cpu_master.md
# axil_cpu_master

- Bridges the CPU's single-outstanding load/store port onto an AXI4-Lite master interface.
- Sits directly upstream of the BRAM AXI-Lite memory slave, either through the interconnect or point-to-point.
- Accepts one request at a time, drives the AW/W/B or AR/R channels independently per AXI-Lite rules, and returns read data and response status to the CPU as a one-cycle completion pulse.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; fixed at 32 in this revision
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  one clock; reset is synchronous and active-high
- mem_valid  in  1  single-cycle request pulse; honoured only while mem_ready=1
- mem_ready  out  1  block idle, can accept a request (combinational from state)
- mem_we  in  1  1=store, 0=load
- mem_addr  in  ADDR_WIDTH  byte address
- mem_wdata  in  DATA_WIDTH  store data
- mem_wstrb  in  STRB_WIDTH  store byte enables
- mem_done  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_WIDTH  load data; valid while mem_done=1, held afterwards
- mem_err  out  1  nonzero RRESP/BRESP; valid while mem_done=1
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel; awprot = 3'b000
- m_axil_awready  in  1
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  write data channel
- m_axil_wready  in  1
- m_axil_bresp  in  2 ; m_axil_bvalid  in  1 ; m_axil_bready  out  1
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel; arprot = 3'b000
- m_axil_arready  in  1
- m_axil_rdata  in  DATA_WIDTH ; m_axil_rresp  in  2 ; m_axil_rvalid  in  1 ; m_axil_rready  out  1

## Operation
- States: IDLE, WADDR (AW and W pending), WRESP, RADDR, RDATA, DONE.
- IDLE, mem_valid=1: latch addr (bits [1:0] forced to 0), wdata, wstrb.
  - If mem_we=1: go to WADDR with awvalid=wvalid=1.
  - Otherwise: go to RADDR with arvalid=1.
- WADDR: awvalid and wvalid are each cleared independently on their own handshake (aw_done/w_done flags). Leave when both are done, including when both handshake in the same cycle.
- WRESP: bready=1. On bvalid, capture err=(bresp!=0) and go to DONE.
- RADDR: arvalid held until arready, then go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata and err=(rresp!=0), then go to DONE.
- DONE: mem_done=1 for exactly one cycle, then IDLE.
- Valid signals never depend combinationally on ready inputs. A valid, once asserted, stays high with stable payload until its handshake.
- bready is 1 only in WRESP; rready is 1 only in RDATA.
- mem_valid while mem_ready=0 is ignored: no queueing, no error.

## Timing
- Reset values: all *valid, bready, rready, mem_done, mem_err = 0; mem_rdata = 0; state = IDLE, so mem_ready=1.
- Request pulse in cycle 0 → channel valid(s) high in cycle 1.
- Read with an always-ready slave and 1-cycle R latency: AR handshake c1, R handshake c2, mem_done c3.
- Write with an always-ready slave: AW/W handshake c1, B handshake c3, mem_done c4.
- Minimum request-to-request spacing: completion pulse cycle + 1. mem_ready rises in the cycle after mem_done.
- A slave holding ready=0 indefinitely stalls the block indefinitely; there is no timeout.
- areset mid-transaction returns the block to reset values on the next edge, and any pending handshake is dropped. This is permitted only because the interconnect and slaves are reset in the same cycle.

## Configuration
- AXIL_MASTER_POSTED_WRITE_EN
- Defined:
  - Stores complete toward the CPU once both AW and W have handshaken: WADDR → DONE, mem_err=0.
  - The B response is collected in the background (bready=1 while outstanding).
  - mem_ready stays 0 until that B arrives, so only one write is ever outstanding.
  - BRESP is discarded.
- Not defined: stores complete only after B, as in Operation.
- Reads are unaffected in both cases.

## Test plan
- Store addr 0x0000_0104, data 0xDEADBEEF, wstrb 0xF, always-ready slave:
  - awaddr=0x104, wdata/wstrb as given.
  - mem_done 4 cycles after the request, mem_err=0.
  - Reading 0x104 back returns 0xDEADBEEF.
- Store wstrb=0b0010, data 0x0000AA00 to a word holding 0x11223344 → reading it back returns 0x1122AA44.
- Store with wready low for 5 cycles while awready=1:
  - awvalid drops after 1 cycle; wvalid is held 6 cycles with stable payload.
  - Exactly one mem_done pulse.
- Load with arready delayed 3 cycles, rvalid delayed 2 further cycles, rresp=2'b10 → mem_done with mem_err=1 and mem_rdata equal to the returned rdata.
- mem_valid pulsed while busy, then areset asserted mid-read:
  - The busy pulse is ignored.
  - After reset all valids=0 and mem_ready=1.
  - The next load completes normally.
- With AXIL_MASTER_POSTED_WRITE_EN, B delayed 4 cycles:
  - mem_done is 2 cycles after the request.
  - mem_ready stays 0 until the cycle after the B handshake.
